per_sram: RTL

Parametrised single-port word RAM peripheral on the XSimBus device side, successor to the fixed 64-word bus RAM. It adds configurable depth, per-byte write strobes, a registered read path with a one-cycle request/acknowledge handshake, out-of-range error reporting, and an optional hardware clear-on-reset sweep. It sits behind the bus decoder and is selected through `select_as_in` like every other peripheral.

---
 rtl/per_sram.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/per_sram.sv
// per_sram: parametrised single-port word RAM on the XSimBus device side.
// Byte-strobed writes, registered read data, one-cycle ack, out-of-range
// error flag. Optional hardware clear sweep after reset is enabled by
// defining the macro PER_SRAM_CLEAR_ON_RESET_EN.
// DEPTH_LOG2 must lie in 2..12. The address bus is wide enough for 4096 words.

package per_sram_pkg;
    localparam int XSIM_ADDR_W = 16;

    typedef logic [1:0]             SelectModeBus;
    typedef logic [XSIM_ADDR_W-1:0] XSimBusDeviceAddressBus;
    typedef logic [31:0]            MemByteBus;

    localparam SelectModeBus SelectNone     = 2'd0;
    localparam SelectModeBus SelectAsDevice = 2'd1;
    localparam SelectModeBus SelectAsHost   = 2'd2;

    localparam logic RWInoutR = 1'b0;
    localparam logic RWInoutW = 1'b1;
endpackage

module per_sram
    import per_sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  SelectModeBus           select_as_in,
    input  XSimBusDeviceAddressBus addr_in,
    input  MemByteBus              data_in,
    input  logic [3:0]             byte_en_in,
    input  logic                   rw_in,
    input  logic                   req_in,
    output MemByteBus              data_out,
    output logic                   ack_out,
    output logic                   err_out,
    output logic                   busy_out
);

    localparam int WORDS = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1
`ifdef PER_SRAM_CLEAR_ON_RESET_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } state_t;

    // Storage; contents are deliberately not reset in the default build.
    MemByteBus r_mem [0:WORDS-1];

    state_t    r_state;
    MemByteBus r_data;
    logic      r_ack;
    logic      r_err;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oor;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_wr_hit;
    logic                  w_clear_we;
    logic                  w_unused;

    // Word index ignores the byte offset; any address bit above the array
    // span makes the access out of range.
    assign w_idx    = addr_in[DEPTH_LOG2+1:2];
    assign w_oor    = (addr_in >> (DEPTH_LOG2 + 2)) != '0;
    assign w_unused = ^addr_in[1:0];

    // Reset blocks acceptance so a request coinciding with reset is dropped
    // rather than half-executed (memory written but ack lost).
    assign w_accept = req_in && (select_as_in == SelectAsDevice) && !w_busy && !rst;
    assign w_wr_hit = w_accept && (rw_in == RWInoutW) && !w_oor;

`ifdef PER_SRAM_CLEAR_ON_RESET_EN
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

    logic [DEPTH_LOG2-1:0] r_cnt;
    logic                  r_busy;

    assign w_busy     = r_busy;
    assign w_clear_we = (r_state == ST_CLEAR) && !rst;
`else
    assign w_busy     = 1'b0;
    assign w_clear_we = 1'b0;
`endif

    // Memory array: clear sweep writes zeros, accepted in-range writes merge
    // the enabled byte lanes. The two never coincide since busy blocks accept.
    always_ff @(posedge clk) begin
`ifdef PER_SRAM_CLEAR_ON_RESET_EN
        if (w_clear_we) begin
            r_mem[r_cnt] <= '0;
        end else
`endif
        if (w_wr_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_in[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered ack/err/data outputs and, when enabled,
    // the clear-sweep counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
`ifdef PER_SRAM_CLEAR_ON_RESET_EN
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`else
            r_state <= ST_IDLE;
`endif
        end else begin
            case (r_state)
`ifdef PER_SRAM_CLEAR_ON_RESET_EN
                ST_CLEAR: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                ST_IDLE, ST_RESP: begin
                    r_ack <= w_accept;
                    r_err <= w_accept && w_oor;
                    if (w_accept && (rw_in == RWInoutR)) begin
                        r_data <= w_oor ? '0 : r_mem[w_idx];
                    end
                    r_state <= w_accept ? ST_RESP : ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data;
    assign ack_out  = r_ack;
    assign err_out  = r_err;
    assign busy_out = w_busy;

endmodule
